uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter PARITYMODE, default 1'b0, meaning the expected parity bit equals XOR of the 8 data bits XOR PARITYMODE (0 = even parity).
REQ-002 SHALL have port clk  input  1  system clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have port clk_bd  input  1  one-clk-wide enable tick at 16x baud rate.
REQ-005 SHALL have port rx  input  1  asynchronous serial line; idles high.
REQ-006 SHALL have port dataout  output  8  last received data byte.
REQ-007 SHALL have port rdsig  output  1  one-clk pulse when a frame completes.
REQ-008 SHALL have port dataerror  output  1  parity mismatch on the last completed frame.
REQ-009 SHALL have port frameerror  output  1  stop bit sampled low on the last completed frame.
REQ-010 SHALL have port busy  output  1  high from start-bit detection until frame completion or abort.

Function
REQ-011 SHALL accept this frame format: start(0), data bits 0..7 LSB first, parity, stop(1); each bit lasts 16 clk_bd ticks.
REQ-012 SHALL pass rx through a 2-FF synchronizer (both stages reset to 1) before any use; all decisions use the synchronized value.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP, with a 4-bit tick counter and a 3-bit bit index.
REQ-014 IDLE: on a synchronized rx 1->0 transition, SHALL clear the tick counter, set busy=1 and go to START.
REQ-015 The tick counter SHALL advance only on clk_bd; the sample point of every bit is tick 7 of that bit.
REQ-016 START: if rx samples high at the sample point (false start), SHALL return to IDLE with busy=0 and no rdsig.
REQ-017 START: otherwise, SHALL go to DATA after 16 further ticks, so that every later sample falls mid-bit.
REQ-018 DATA: SHALL shift each sample into bit position = bit index; after bit 7, SHALL go to PARITY.
REQ-019 PARITY: SHALL compare the sample against the XOR of the data bits XOR PARITYMODE.
REQ-020 STOP: on the stop-bit sample tick, SHALL return to IDLE immediately (mid-stop, for resync) with busy=0.
REQ-021 On the clk following the STOP sample tick, SHALL load dataout, set dataerror and frameerror, and pulse rdsig high for exactly 1 clk.
REQ-022 dataout, dataerror and frameerror SHALL hold their values until the next completed frame; an aborted start SHALL leave them unchanged.
REQ-023 After a frameerror (rx stuck low), SHALL not detect a new start until rx has been sampled high, because start detection requires a 1->0 edge.
REQ-024 Back-to-back frames (next start edge arriving 8 ticks after the stop sample) SHALL be received without loss.
REQ-025 clk_bd ticks arriving while in IDLE SHALL have no effect.

Reset
REQ-026 While rst=1, SHALL force state=IDLE, counters=0, synchronizer=1, dataout=8'h00, rdsig=0, dataerror=0, frameerror=0, busy=0.
REQ-027 Asserting rst mid-frame SHALL abort the frame with no rdsig; after release, SHALL wait for a fresh 1->0 edge.

Configuration
REQ-028 SHALL support macro UART_RX_MAJORITY_EN.
REQ-029 With UART_RX_MAJORITY_EN defined, every bit value (start, data, parity, stop) SHALL be the 2-of-3 majority of samples at ticks 6, 7 and 8, decided at tick 8; all other timing shifts by one tick.
REQ-030 Without UART_RX_MAJORITY_EN, every bit value SHALL be the single sample at tick 7.

Verification
REQ-031 Frame 0x55 with parity bit 0 and stop bit 1 -> dataout=8'h55, one rdsig pulse, dataerror=0, frameerror=0, busy=0 afterwards.
REQ-032 Frame 0xA3 with parity bit 1 (wrong; expected 0) -> dataout=8'hA3, rdsig pulse, dataerror=1.
REQ-033 Frame 0x0F with stop bit 0 -> rdsig pulse, frameerror=1; the next valid frame 0x3C -> frameerror=0, dataout=8'h3C.
REQ-034 rx low for 4 ticks only -> busy rises then falls, no rdsig, dataout unchanged.
REQ-035 rst pulsed during data bit 3, then a full frame 0x81 -> no rdsig for the aborted frame, then dataout=8'h81.
REQ-036 1-tick low glitch at tick 7 of data bit 0 of frame 0xFF -> with the macro, dataout=8'hFF; without it, dataout=8'hFE and dataerror=1.

Source files
------------

// File: rtl/uart_rx_if.sv
// UART receiver bus: serial input with its 16x baud tick, and the
// received-byte result signals. The receiver uses the slave modport.
interface uart_rx_if;
    logic       clk_bd;
    logic       rx;
    logic [7:0] dataout;
    logic       rdsig;
    logic       dataerror;
    logic       frameerror;
    logic       busy;

    modport master (
        output clk_bd, rx,
        input  dataout, rdsig, dataerror, frameerror, busy
    );

    modport slave (
        input  clk_bd, rx,
        output dataout, rdsig, dataerror, frameerror, busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, parity, stop; 16 ticks/bit.
// Optional macro UART_RX_MAJORITY_EN: each bit is the 2-of-3 majority of
// the samples at ticks 6, 7 and 8, decided at tick 8 (otherwise the
// single sample at tick 7 is used).
module uart_rx #(
    parameter logic PARITYMODE = 1'b0
) (
    input logic       clk,
    input logic       rst,
    uart_rx_if.slave  bus
);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] SAMP = 4'd8;
`else
    localparam logic [3:0] SAMP = 4'd7;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t     state;
    logic [3:0] tick_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic       par_bit;
    logic       stop_bit;
    logic       done;
    logic       rx_s1, rx_s2, rx_prev;
    logic       bit_val;
    logic       sample;
    logic       bit_end;

    // Two-stage synchronizer plus one delayed copy for 1->0 edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= bus.rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic s6, s7;

    // Capture the early samples; the third one is the live value at tick 8.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s6 <= 1'b1;
            s7 <= 1'b1;
        end else if (bus.clk_bd) begin
            if (tick_cnt == 4'd6) s6 <= rx_s2;
            if (tick_cnt == 4'd7) s7 <= rx_s2;
        end
    end

    assign bit_val = (s6 & s7) | (s6 & rx_s2) | (s7 & rx_s2);
`else
    assign bit_val = rx_s2;
`endif

    assign sample  = bus.clk_bd && (tick_cnt == SAMP);
    assign bit_end = bus.clk_bd && (tick_cnt == 4'd15);

    // Frame FSM; results are published one clk after the stop sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            tick_cnt       <= 4'd0;
            bit_idx        <= 3'd0;
            shreg          <= 8'h00;
            par_bit        <= 1'b0;
            stop_bit       <= 1'b1;
            done           <= 1'b0;
            bus.dataout    <= 8'h00;
            bus.rdsig      <= 1'b0;
            bus.dataerror  <= 1'b0;
            bus.frameerror <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.rdsig <= 1'b0;
            done      <= 1'b0;
            if (done) begin
                bus.dataout    <= shreg;
                bus.dataerror  <= par_bit ^ (^shreg) ^ PARITYMODE;
                bus.frameerror <= ~stop_bit;
                bus.rdsig      <= 1'b1;
            end
            if (state != IDLE && bus.clk_bd)
                tick_cnt <= tick_cnt + 4'd1;
            case (state)
                IDLE: begin
                    // Ticks are ignored here; only a fresh falling edge starts a frame.
                    if (rx_prev && !rx_s2) begin
                        tick_cnt <= 4'd0;
                        bit_idx  <= 3'd0;
                        bus.busy <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (sample && bit_val) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else if (bit_end) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (sample) shreg[bit_idx] <= bit_val;
                    if (bit_end) begin
                        if (bit_idx == 3'd7) state <= PARITY;
                        else bit_idx <= bit_idx + 3'd1;
                    end
                end
                PARITY: begin
                    if (sample)  par_bit <= bit_val;
                    if (bit_end) state   <= STOP;
                end
                STOP: begin
                    // Leave mid-stop so the next start edge can be seen early.
                    if (sample) begin
                        stop_bit <= bit_val;
                        done     <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are built as arrays of per-tick line
// levels; the expected byte/flags come from the bit-sampling rule applied
// to that array and are queued for an independent rdsig monitor.
module tb_uart_rx;
    localparam logic PM = 1'b0;

    typedef struct packed {
        logic [7:0] d;
        logic       de;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] bd_cnt = 2'd0;
    int         total = 0;
    int         bad = 0;
    exp_t       q[$];
    logic       segs[0:255];
    logic [7:0] last_data = 8'h00;
    logic       rd_prev = 1'b0;

    uart_rx_if bus();

    uart_rx #(.PARITYMODE(PM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) bd_cnt <= bd_cnt + 2'd1;
    assign bus.clk_bd = (bd_cnt == 2'd0);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Value of frame bit b as the receiver is required to decide it.
    function automatic logic bit_at(input int b);
`ifdef UART_RX_MAJORITY_EN
        int a = segs[b*16+6], m = segs[b*16+7], c = segs[b*16+8];
        return ((a + m + c) >= 2);
`else
        return segs[b*16+7];
`endif
    endfunction

    function automatic exp_t model();
        exp_t e;
        for (int i = 0; i < 8; i++) e.d[i] = bit_at(i + 1);
        e.de = (bit_at(9) != ((^e.d) ^ PM));
        e.fe = (bit_at(10) == 1'b0);
        return e;
    endfunction

    task automatic drive_lvl(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            bus.rx = v;
            @(posedge clk iff bus.clk_bd);
            #1;
        end
    endtask

    task automatic drive_segs(input int n);
        for (int i = 0; i < n; i++) begin
            bus.rx = segs[i];
            @(posedge clk iff bus.clk_bd);
            #1;
        end
    endtask

    task automatic build(input logic [7:0] d, input logic par, input logic stp, input int glitch);
        logic v;
        for (int b = 0; b < 11; b++) begin
            if (b == 0)      v = 1'b0;
            else if (b <= 8) v = d[b-1];
            else if (b == 9) v = par;
            else             v = stp;
            for (int s = 0; s < 16; s++) segs[b*16+s] = v;
        end
        if (glitch >= 0) segs[glitch] = ~segs[glitch];
    endtask

    task automatic send(input logic [7:0] d, input logic par, input logic stp, input int glitch, input int gap);
        build(d, par, stp, glitch);
        for (int g = 0; g < gap; g++) segs[176+g] = 1'b1;
        q.push_back(model());
        drive_segs(176 + gap);
    endtask

    // Monitor: every rdsig pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.rdsig) begin
            chk("rdsig_width", {31'd0, rd_prev}, 32'd0);
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rdsig actual=%0h required=none", bus.dataout);
            end else begin
                e = q.pop_front();
                chk("dataout", {24'd0, bus.dataout}, {24'd0, e.d});
                chk("dataerror", {31'd0, bus.dataerror}, {31'd0, e.de});
                chk("frameerror", {31'd0, bus.frameerror}, {31'd0, e.fe});
                chk("busy_after", {31'd0, bus.busy}, 32'd0);
                last_data = e.d;
            end
        end
        rd_prev = bus.rdsig;
    end

    initial begin
        logic [7:0] d;
        logic       par, stp;
        int         gl, gap;

        bus.rx = 1'b1;
        #2 rst = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_dataout", {24'd0, bus.dataout}, 32'd0);
        chk("rst_rdsig", {31'd0, bus.rdsig}, 32'd0);
        chk("rst_dataerror", {31'd0, bus.dataerror}, 32'd0);
        chk("rst_frameerror", {31'd0, bus.frameerror}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;
        drive_lvl(1'b1, 6);

        // Directed frames: clean, bad parity, bad stop then recovery.
        send(8'h55, 1'b0, 1'b1, -1, 2);
        send(8'hA3, 1'b1, 1'b1, -1, 2);
        send(8'h0F, 1'b0, 1'b0, -1, 4);
        send(8'h3C, 1'b0, 1'b1, -1, 2);

        // False start: four low ticks only.
        drive_lvl(1'b0, 2);
        chk("fs_busy_hi", {31'd0, bus.busy}, 32'd1);
        drive_lvl(1'b0, 2);
        drive_lvl(1'b1, 20);
        chk("fs_busy_lo", {31'd0, bus.busy}, 32'd0);
        chk("fs_dataout", {24'd0, bus.dataout}, {24'd0, last_data});

        // Reset in the middle of data bit 3, then a full frame.
        build(8'h81, 1'b0, 1'b1, -1);
        drive_segs(4*16 + 6);
        rst = 1'b1;
        bus.rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_dataout", {24'd0, bus.dataout}, 32'd0);
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;
        drive_lvl(1'b1, 10);
        send(8'h81, 1'b0, 1'b1, -1, 2);

        // Single-tick glitch at tick 7 of data bit 0.
        send(8'hFF, 1'b0, 1'b1, 16 + 7, 2);

        // Randomized frames, including back-to-back (zero gap) traffic.
        for (int n = 0; n < 36; n++) begin
            d   = 8'($urandom);
            par = (^d) ^ PM;
            if ($urandom_range(0, 9) == 0) par = ~par;
            stp = ($urandom_range(0, 9) != 0);
            gl  = ($urandom_range(0, 1) == 1) ? 16 + int'($urandom_range(0, 143)) : -1;
            gap = stp ? int'($urandom_range(0, 2)) : 3;
            send(d, par, stp, gl, gap);
        end

        drive_lvl(1'b1, 40);
        chk("queue_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
